// File: rtl/xorshift_stream_gen_pkg.sv
// Shared types and defaults for the xorshift stream generator.
package xorshift_stream_gen_pkg;

    // Job sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHIFT_A = 13;
    localparam int unsigned DEF_SHIFT_B = 17;
    localparam int unsigned DEF_SHIFT_C = 5;
    localparam int unsigned DEF_CNT_W   = 9;

    // Substitute seed so an all-zero seed never locks the generator at zero
    localparam logic [31:0] DEF_ZERO_SEED = 32'h2545_F491;

endpackage

// File: rtl/xorshift_step.sv
// Combinational xorshift step: three single sub-steps of the input plus the chained full step.
module xorshift_step
    import xorshift_stream_gen_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHIFT_A = DEF_SHIFT_A,
    parameter int unsigned SHIFT_B = DEF_SHIFT_B,
    parameter int unsigned SHIFT_C = DEF_SHIFT_C
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] sub_a_o,
    output logic [WIDTH-1:0] sub_b_o,
    output logic [WIDTH-1:0] sub_c_o,
    output logic [WIDTH-1:0] full_o
);

    logic [WIDTH-1:0] chain_a;
    logic [WIDTH-1:0] chain_b;

    // Each sub-step applied on its own to x_i, used by the iterative path one per cycle
    assign sub_a_o = x_i ^ (x_i << SHIFT_A);
    assign sub_b_o = x_i ^ (x_i >> SHIFT_B);
    assign sub_c_o = x_i ^ (x_i << SHIFT_C);

    // Full step in order A, B, C, used by the fast path
    assign chain_a = x_i ^ (x_i << SHIFT_A);
    assign chain_b = chain_a ^ (chain_a >> SHIFT_B);
    assign full_o  = chain_b ^ (chain_b << SHIFT_C);

endmodule

// File: rtl/xorshift_stream_gen.sv
// Job-based xorshift number stream with valid/ready output, fast or iterative update.
module xorshift_stream_gen
    import xorshift_stream_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SHIFT_A   = DEF_SHIFT_A,
    parameter int unsigned SHIFT_B   = DEF_SHIFT_B,
    parameter int unsigned SHIFT_C   = DEF_SHIFT_C,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter logic [31:0] ZERO_SEED = DEF_ZERO_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    input  logic             fast_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_num,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZSEED = WIDTH'(ZERO_SEED);

    state_e           state_q;
    logic [1:0]       k_q;
    logic [WIDTH-1:0] x_q;
    logic [CNT_W-1:0] remaining_q;
    logic             mode_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] rand_num_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] x_sub_a_d;
    logic [WIDTH-1:0] x_sub_b_d;
    logic [WIDTH-1:0] x_sub_c_d;
    logic [WIDTH-1:0] x_full_d;
    logic [WIDTH-1:0] seed_sel;

    // In OUTPUT x_q mirrors rand_num_q, so one step instance serves both CALC and fast OUTPUT
    xorshift_step #(
        .WIDTH   (WIDTH),
        .SHIFT_A (SHIFT_A),
        .SHIFT_B (SHIFT_B),
        .SHIFT_C (SHIFT_C)
    ) u_step (
        .x_i     (x_q),
        .sub_a_o (x_sub_a_d),
        .sub_b_o (x_sub_b_d),
        .sub_c_o (x_sub_c_d),
        .full_o  (x_full_d)
    );

    assign seed_sel = (seed == '0) ? ZSEED : seed;

    // Job sequencer: accept, compute, hold output under backpressure, finish with a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            x_q         <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rand_num_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q         <= seed_sel;
                        remaining_q <= count;
                        mode_q      <= fast_mode;
                        busy_q      <= 1'b1;
                        k_q         <= 2'd0;
                        state_q     <= (count == '0) ? ST_FINISH : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (mode_q) begin
                        x_q         <= x_full_d;
                        rand_num_q  <= x_full_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUTPUT;
                    end else begin
                        case (k_q)
                            2'd0: begin
                                x_q <= x_sub_a_d;
                                k_q <= 2'd1;
                            end
                            2'd1: begin
                                x_q <= x_sub_b_d;
                                k_q <= 2'd2;
                            end
                            default: begin
                                x_q         <= x_sub_c_d;
                                rand_num_q  <= x_sub_c_d;
                                out_valid_q <= 1'b1;
                                k_q         <= 2'd0;
                                state_q     <= ST_OUTPUT;
                            end
                        endcase
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_FINISH;
                        end else if (mode_q) begin
                            x_q        <= x_full_d;
                            rand_num_q <= x_full_d;
                        end else begin
                            out_valid_q <= 1'b0;
                            k_q         <= 2'd0;
                            state_q     <= ST_CALC;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign rand_num  = rand_num_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
